mc_controller: RTL and testbench
================================

Name: mc_controller

Overview:
- Multicycle control unit for the ARM-subset processor; replaces the single-cycle decoder-only control path.
- Contains the main state machine, the NZCV flags register and condition-check logic.
- Sequences the shared datapath (one memory port, one ALU, one iterative multiplier) over several cycles per instruction.
- Sits between the instruction register and the multicycle datapath; drives every mux select and write enable.

Parameters:
- none (all encodings live in the shared package)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- Cond  in  4  Instr[31:28]
- Op  in  2  Instr[27:26]
- Funct  in  6  Instr[25:20]; [5]=I, [4:1]=cmd, [0]=S
- Rd  in  4  Instr[15:12]
- ALUFlags  in  4  NZCV from the ALU, current cycle
- MulDone  in  1  iterative multiplier finished; result valid this cycle
- PCWrite  out  1  PC register enable
- MemWrite  out  1  data memory write enable
- RegWrite  out  1  register file write enable
- IRWrite  out  1  instruction register enable
- AdrSrc  out  1  0=PC, 1=ALU result as memory address
- RegSrc  out  2  register file read-address selects, same meaning as single-cycle
- ImmSrc  out  2  extend unit select: 00 DP imm8, 01 mem imm12, 10 branch imm24
- ALUSrcA  out  2  00 RD1, 01 PC, 10 ALUOut
- ALUSrcB  out  2  00 RD2/WriteData, 01 ExtImm, 10 constant 4
- ResultSrc  out  2  00 ALUOut, 01 Data, 10 ALU result direct, 11 multiplier result
- ALUControl  out  4  ALU operation code (package)
- MulStart  out  1  single-cycle pulse launching the multiplier

Behaviour:
- States and transitions:
  - FETCH -> DECODE.
  - DECODE -> one of:
    - MEMADR (Op=01)
    - EXECUTER (Op=00, I=0)
    - EXECUTEI (Op=00, I=1)
    - BRANCH (Op=10)
    - FETCH (Op=11, treated as NOP)
  - MEMADR -> MEMRD if Funct[0]=1, else MEMWR.
  - MEMRD -> MEMWB -> FETCH.
  - MEMWR -> FETCH.
  - EXECUTER/EXECUTEI -> MULWAIT if cmd is MUL/MLA/MLS, else ALUWB.
  - MULWAIT -> ALUWB when MulDone=1, else stay.
  - ALUWB -> FETCH.
  - BRANCH -> FETCH.
- Latency (cycles, incl. fetch):
  - DP: 4
  - LDR: 5
  - STR: 4
  - B: 3
  - MUL family: 5 + cycles waiting in MULWAIT (minimum 1 MULWAIT cycle)
- FETCH: IRWrite=1, PCWrite=1 (unconditional), AdrSrc=0, ALUSrcA=01, ALUSrcB=10, ALUControl=ADD, ResultSrc=10.
- DECODE:
  - ALUSrcA=01, ALUSrcB=10, ALUControl=ADD, which produces PC+8 for the R15 read.
  - Evaluates Cond against the flags register and latches the result into cond_ex_q.
- Condition codes:
  - Standard ARM EQ..LE, plus AL=1110.
  - 1111 evaluates false.
- cond_ex_q gates RegWrite, MemWrite, the PCWrite of ALUWB/MEMWB/BRANCH, MulStart and flag updates.
  - A failed condition still walks the full state path, with no architectural side effects.
- MEMADR: ALUSrcA=00, ALUSrcB=01, ImmSrc=01, ALUControl=ADD (U-bit subtract not supported).
- MEMRD/MEMWR: AdrSrc=1. MEMWR additionally drives MemWrite=cond_ex_q.
- MEMWB: ResultSrc=01.
  - Rd=15: PCWrite=cond_ex_q.
  - otherwise: RegWrite=cond_ex_q.
- EXECUTER/EXECUTEI:
  - ALUSrcB=00 (R) or 01 with ImmSrc=00 (I).
  - ALUControl decoded from cmd: 1101 MOV, 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR, 1001 MUL, 1010 MLA, 1011 MLS, 0011 SBC, 0111 RSB, 0101 ADC.
  - Unlisted cmd: ALUControl=ADD; state path unchanged; RegWrite forced 0 in ALUWB.
  - MulStart=cond_ex_q for MUL/MLA/MLS.
- ALUWB:
  - ResultSrc=00, or 11 after MULWAIT.
  - Rd=15: PCWrite=cond_ex_q.
  - otherwise: RegWrite=cond_ex_q.
- Flags register: updated at the clock edge that leaves EXECUTER/EXECUTEI, or leaves MULWAIT for multiplies, using that cycle's ALUFlags.
  - NZ written when S=1 and cond_ex_q.
  - CV written when S=1, cond_ex_q, and cmd in {ADD, SUB, ADC, SBC, RSB}.
- BRANCH: ALUSrcA=10, ALUSrcB=01, ImmSrc=10, ALUControl=ADD, ResultSrc=10, PCWrite=cond_ex_q.
- Outputs not listed for a state are 0 / 00 (ALUControl=ADD).
- Reset:
  - Asynchronous; state=FETCH, flags=0000, cond_ex_q=0.
  - While reset=1, PCWrite, MemWrite, RegWrite, IRWrite and MulStart are forced 0.
  - Reset in MULWAIT abandons the multiply: no write.
- MulDone outside MULWAIT is ignored.

Decomposition:
- Package mc_pkg holds:
  - state enum
  - ALU opcode constants (4-bit)
  - select encodings for ResultSrc, ALUSrcA, ALUSrcB, ImmSrc
  - condition-code constants
- One sub-module, cond_check: combinational Cond + flags -> CondEx. The flags register stays in mc_controller.

Test Plan:
- Reset pulse mid-MEMRD -> next state FETCH; no write enable asserted during reset; flags=0000.
- ADDS R1,R2,R3 with ALUFlags=0110 in EXECUTER -> 4-cycle sequence; RegWrite=1 in ALUWB; flags=0110 afterwards.
- ANDS with ALUFlags=1011 after flags=0110 -> flags=1010 (NZ updated, CV kept).
- BEQ with Z=0 -> PCWrite=0 in BRANCH; next FETCH PCWrite=1; total 3 cycles.
- LDR Rd=15 -> MEMADR, MEMRD (AdrSrc=1), MEMWB with PCWrite=1, RegWrite=0.
- MUL with MulDone asserted on the 3rd MULWAIT cycle -> single MulStart pulse; ALUWB ResultSrc=11; total 7 cycles. Cond=1111 -> no MulStart, no write.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle control unit:
// FSM states, ALU opcodes, datapath selects and condition codes.
package mc_pkg;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    MEMADR,
    MEMRD,
    MEMWR,
    MEMWB,
    EXECUTER,
    EXECUTEI,
    MULWAIT,
    ALUWB,
    BRANCH
  } state_t;

  // ALU opcodes reuse the instruction cmd field
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0010;
  localparam logic [3:0] ALU_SBC = 4'b0011;
  localparam logic [3:0] ALU_ADD = 4'b0100;
  localparam logic [3:0] ALU_ADC = 4'b0101;
  localparam logic [3:0] ALU_RSB = 4'b0111;
  localparam logic [3:0] ALU_MUL = 4'b1001;
  localparam logic [3:0] ALU_MLA = 4'b1010;
  localparam logic [3:0] ALU_MLS = 4'b1011;
  localparam logic [3:0] ALU_ORR = 4'b1100;
  localparam logic [3:0] ALU_MOV = 4'b1101;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;
  localparam logic [1:0] RES_MUL    = 2'b11;

  localparam logic [1:0] SRCA_RD1    = 2'b00;
  localparam logic [1:0] SRCA_PC     = 2'b01;
  localparam logic [1:0] SRCA_ALUOUT = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_DP  = 2'b00;
  localparam logic [1:0] IMM_MEM = 2'b01;
  localparam logic [1:0] IMM_BR  = 2'b10;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

  function automatic logic is_mul(input logic [3:0] cmd);
    return cmd == ALU_MUL || cmd == ALU_MLA || cmd == ALU_MLS;
  endfunction

  function automatic logic sets_cv(input logic [3:0] cmd);
    return cmd == ALU_ADD || cmd == ALU_SUB || cmd == ALU_ADC ||
           cmd == ALU_SBC || cmd == ALU_RSB;
  endfunction

  function automatic logic cmd_known(input logic [3:0] cmd);
    return sets_cv(cmd) || is_mul(cmd) || cmd == ALU_MOV ||
           cmd == ALU_AND || cmd == ALU_ORR;
  endfunction

endpackage

// File: rtl/mc_controller_cond_check.sv
// Condition-code evaluation of Cond against the NZCV flags.
// Flags order is {N, Z, C, V}; the 1111 encoding never executes.
module cond_check
  import mc_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       cond_ex
);

  logic n, z, c, v;

  assign {n, z, c, v} = flags;

  always_comb begin
    cond_ex = 1'b0;
    case (cond)
      COND_EQ: cond_ex = z;
      COND_NE: cond_ex = !z;
      COND_CS: cond_ex = c;
      COND_CC: cond_ex = !c;
      COND_MI: cond_ex = n;
      COND_PL: cond_ex = !n;
      COND_VS: cond_ex = v;
      COND_VC: cond_ex = !v;
      COND_HI: cond_ex = c && !z;
      COND_LS: cond_ex = !c || z;
      COND_GE: cond_ex = n == v;
      COND_LT: cond_ex = n != v;
      COND_GT: cond_ex = !z && (n == v);
      COND_LE: cond_ex = z || (n != v);
      COND_AL: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle control FSM with NZCV flags register; drives every
// mux select and write enable of the shared datapath.
module mc_controller
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Cond,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  input  logic [3:0] ALUFlags,
  input  logic       MulDone,
  output logic       PCWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic [1:0] RegSrc,
  output logic [1:0] ImmSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [3:0] ALUControl,
  output logic       MulStart
);

  state_t     state, next;
  logic [3:0] flags_q;
  logic       cond_ex_q;
  logic       cond_ex;
  logic [3:0] cmd;
  logic       mul_op;
  logic       to_pc;
  logic       flag_we;

  assign cmd    = Funct[4:1];
  assign mul_op = is_mul(cmd);
  assign to_pc  = Rd == 4'd15;
  assign RegSrc = {Op == 2'b01 && !Funct[0], Op == 2'b10};

  cond_check u_cond (
    .cond   (Cond),
    .flags  (flags_q),
    .cond_ex(cond_ex)
  );

  assign flag_we = cond_ex_q && Funct[0] &&
    (((state == EXECUTER || state == EXECUTEI) && !mul_op) ||
     (state == MULWAIT && next == ALUWB));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= FETCH;
      flags_q   <= 4'b0000;
      cond_ex_q <= 1'b0;
    end else begin
      state <= next;
      if (state == DECODE) cond_ex_q <= cond_ex;
      if (flag_we) begin
        flags_q[3:2] <= ALUFlags[3:2];
        if (sets_cv(cmd)) flags_q[1:0] <= ALUFlags[1:0];
      end
    end
  end

  always_comb begin
    next       = state;
    PCWrite    = 1'b0;
    MemWrite   = 1'b0;
    RegWrite   = 1'b0;
    IRWrite    = 1'b0;
    AdrSrc     = 1'b0;
    ImmSrc     = IMM_DP;
    ALUSrcA    = SRCA_RD1;
    ALUSrcB    = SRCB_RD2;
    ResultSrc  = RES_ALUOUT;
    ALUControl = ALU_ADD;
    MulStart   = 1'b0;
    unique case (state)
      FETCH: begin
        next      = DECODE;
        IRWrite   = 1'b1;
        PCWrite   = 1'b1;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALU;
      end
      DECODE: begin
        ALUSrcA = SRCA_PC;
        ALUSrcB = SRCB_FOUR;
        unique case (Op)
          2'b00:   next = Funct[5] ? EXECUTEI : EXECUTER;
          2'b01:   next = MEMADR;
          2'b10:   next = BRANCH;
          default: next = FETCH;
        endcase
      end
      MEMADR: begin
        next    = Funct[0] ? MEMRD : MEMWR;
        ALUSrcB = SRCB_IMM;
        ImmSrc  = IMM_MEM;
      end
      MEMRD: begin
        next   = MEMWB;
        AdrSrc = 1'b1;
      end
      MEMWR: begin
        next     = FETCH;
        AdrSrc   = 1'b1;
        MemWrite = cond_ex_q;
      end
      MEMWB: begin
        next      = FETCH;
        ResultSrc = RES_DATA;
        PCWrite   = cond_ex_q && to_pc;
        RegWrite  = cond_ex_q && !to_pc;
      end
      EXECUTER, EXECUTEI: begin
        next       = mul_op ? MULWAIT : ALUWB;
        ALUSrcB    = state == EXECUTEI ? SRCB_IMM : SRCB_RD2;
        ALUControl = cmd_known(cmd) ? cmd : ALU_ADD;
        MulStart   = cond_ex_q && mul_op;
      end
      // A squashed multiply was never started, so it cannot wait on MulDone
      MULWAIT: begin
        if (MulDone || !cond_ex_q) next = ALUWB;
      end
      ALUWB: begin
        next      = FETCH;
        ResultSrc = mul_op ? RES_MUL : RES_ALUOUT;
        PCWrite   = cond_ex_q && to_pc;
        RegWrite  = cond_ex_q && !to_pc && cmd_known(cmd);
      end
      BRANCH: begin
        next      = FETCH;
        ALUSrcA   = SRCA_ALUOUT;
        ALUSrcB   = SRCB_IMM;
        ImmSrc    = IMM_BR;
        ResultSrc = RES_ALU;
        PCWrite   = cond_ex_q;
      end
      default: next = FETCH;
    endcase
    if (reset) begin
      PCWrite  = 1'b0;
      MemWrite = 1'b0;
      RegWrite = 1'b0;
      IRWrite  = 1'b0;
      MulStart = 1'b0;
    end
  end

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: walks each instruction class
// cycle by cycle and checks selects, enables and flags.
module tb_mc_controller;
  import mc_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] Cond;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic [3:0] ALUFlags;
  logic       MulDone;
  logic       PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc;
  logic [1:0] RegSrc, ImmSrc, ALUSrcA, ALUSrcB, ResultSrc;
  logic [3:0] ALUControl;
  logic       MulStart;

  int total = 0;
  int bad = 0;

  mc_controller dut (
    .clk       (clk),
    .reset     (reset),
    .Cond      (Cond),
    .Op        (Op),
    .Funct     (Funct),
    .Rd        (Rd),
    .ALUFlags  (ALUFlags),
    .MulDone   (MulDone),
    .PCWrite   (PCWrite),
    .MemWrite  (MemWrite),
    .RegWrite  (RegWrite),
    .IRWrite   (IRWrite),
    .AdrSrc    (AdrSrc),
    .RegSrc    (RegSrc),
    .ImmSrc    (ImmSrc),
    .ALUSrcA   (ALUSrcA),
    .ALUSrcB   (ALUSrcB),
    .ResultSrc (ResultSrc),
    .ALUControl(ALUControl),
    .MulStart  (MulStart)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic inst(input logic [3:0] c, input logic [1:0] o,
                      input logic [5:0] f, input logic [3:0] r);
    Cond  = c;
    Op    = o;
    Funct = f;
    Rd    = r;
  endtask

  task automatic st(input string tag, input state_t exp);
    chk(tag, 8'(dut.state), 8'(exp));
  endtask

  initial begin
    reset = 1'b1;
    ALUFlags = 4'b0000;
    MulDone = 1'b0;
    inst(4'b1110, 2'b00, 6'b000000, 4'd0);
    step();
    st("rst_state", FETCH);
    chk("rst_flags", 8'(dut.flags_q), 8'h0);
    chk("rst_irwrite", 8'(IRWrite), 8'h0);
    chk("rst_pcwrite", 8'(PCWrite), 8'h0);
    reset = 1'b0;
    #1;

    // ADDS R1,R2,R3
    inst(4'b1110, 2'b00, 6'b001001, 4'd1);
    chk("add_f_ir", 8'(IRWrite), 8'h1);
    chk("add_f_pc", 8'(PCWrite), 8'h1);
    chk("add_f_srcb", 8'(ALUSrcB), 8'(SRCB_FOUR));
    chk("add_f_res", 8'(ResultSrc), 8'(RES_ALU));
    step();
    st("add_dec", DECODE);
    chk("add_d_srca", 8'(ALUSrcA), 8'(SRCA_PC));
    step();
    ALUFlags = 4'b0110;
    st("add_exe", EXECUTER);
    chk("add_e_alu", 8'(ALUControl), 8'(ALU_ADD));
    chk("add_e_srcb", 8'(ALUSrcB), 8'(SRCB_RD2));
    chk("add_e_ms", 8'(MulStart), 8'h0);
    step();
    ALUFlags = 4'b0000;
    st("add_wb", ALUWB);
    chk("add_wb_rw", 8'(RegWrite), 8'h1);
    chk("add_wb_pc", 8'(PCWrite), 8'h0);
    chk("add_flags", 8'(dut.flags_q), 8'h6);
    step();
    st("add_done", FETCH);

    // ANDS immediate, flags NZ only
    inst(4'b1110, 2'b00, 6'b100001, 4'd2);
    step();
    step();
    ALUFlags = 4'b1011;
    st("and_exe", EXECUTEI);
    chk("and_alu", 8'(ALUControl), 8'(ALU_AND));
    chk("and_srcb", 8'(ALUSrcB), 8'(SRCB_IMM));
    chk("and_imm", 8'(ImmSrc), 8'(IMM_DP));
    step();
    ALUFlags = 4'b0000;
    chk("and_flags", 8'(dut.flags_q), 8'hA);
    step();

    // BEQ with Z=0: not taken
    inst(4'b0000, 2'b10, 6'b000000, 4'd0);
    step();
    step();
    st("beq_br", BRANCH);
    chk("beq_pc", 8'(PCWrite), 8'h0);
    chk("beq_srca", 8'(ALUSrcA), 8'(SRCA_ALUOUT));
    chk("beq_imm", 8'(ImmSrc), 8'(IMM_BR));
    step();
    st("beq_done", FETCH);
    chk("beq_f_pc", 8'(PCWrite), 8'h1);

    // BNE with Z=0: taken
    inst(4'b0001, 2'b10, 6'b000000, 4'd0);
    step();
    step();
    chk("bne_pc", 8'(PCWrite), 8'h1);
    step();

    // LDR PC
    inst(4'b1110, 2'b01, 6'b011001, 4'd15);
    step();
    step();
    st("ldr_adr", MEMADR);
    chk("ldr_imm", 8'(ImmSrc), 8'(IMM_MEM));
    chk("ldr_srcb", 8'(ALUSrcB), 8'(SRCB_IMM));
    step();
    st("ldr_rd", MEMRD);
    chk("ldr_adrsrc", 8'(AdrSrc), 8'h1);
    step();
    st("ldr_wb", MEMWB);
    chk("ldr_res", 8'(ResultSrc), 8'(RES_DATA));
    chk("ldr_pc", 8'(PCWrite), 8'h1);
    chk("ldr_rw", 8'(RegWrite), 8'h0);
    step();
    st("ldr_done", FETCH);

    // STR
    inst(4'b1110, 2'b01, 6'b011000, 4'd2);
    step();
    chk("str_regsrc", 8'(RegSrc), 8'h2);
    step();
    step();
    st("str_wr", MEMWR);
    chk("str_mw", 8'(MemWrite), 8'h1);
    chk("str_adrsrc", 8'(AdrSrc), 8'h1);
    step();
    st("str_done", FETCH);

    // MUL, MulDone on 3rd wait cycle
    inst(4'b1110, 2'b00, 6'b010010, 4'd4);
    step();
    step();
    chk("mul_alu", 8'(ALUControl), 8'(ALU_MUL));
    chk("mul_ms_e", 8'(MulStart), 8'h1);
    step();
    st("mul_w1", MULWAIT);
    chk("mul_ms_w1", 8'(MulStart), 8'h0);
    step();
    st("mul_w2", MULWAIT);
    chk("mul_ms_w2", 8'(MulStart), 8'h0);
    step();
    MulDone = 1'b1;
    st("mul_w3", MULWAIT);
    step();
    MulDone = 1'b0;
    st("mul_wb", ALUWB);
    chk("mul_res", 8'(ResultSrc), 8'(RES_MUL));
    chk("mul_rw", 8'(RegWrite), 8'h1);
    step();
    st("mul_done", FETCH);
    chk("mul_flags", 8'(dut.flags_q), 8'hA);

    // MULS with Cond=1111: no start, no write, no flags
    inst(4'b1111, 2'b00, 6'b010011, 4'd4);
    step();
    step();
    ALUFlags = 4'b0101;
    chk("nv_ms", 8'(MulStart), 8'h0);
    step();
    MulDone = 1'b1;
    step();
    MulDone = 1'b0;
    st("nv_wb", ALUWB);
    chk("nv_rw", 8'(RegWrite), 8'h0);
    step();
    ALUFlags = 4'b0000;
    chk("nv_flags", 8'(dut.flags_q), 8'hA);

    // Unlisted cmd 1000: ADD op, no register write
    inst(4'b1110, 2'b00, 6'b010000, 4'd3);
    step();
    step();
    chk("unk_alu", 8'(ALUControl), 8'(ALU_ADD));
    step();
    st("unk_wb", ALUWB);
    chk("unk_rw", 8'(RegWrite), 8'h0);
    step();

    // Reset mid-MEMRD
    inst(4'b1110, 2'b01, 6'b011001, 4'd3);
    step();
    step();
    step();
    st("rr_rd", MEMRD);
    reset = 1'b1;
    #1;
    st("rr_state", FETCH);
    chk("rr_flags", 8'(dut.flags_q), 8'h0);
    chk("rr_en", 8'({PCWrite, MemWrite, RegWrite, IRWrite, MulStart}), 8'h0);
    step();
    chk("rr_en2", 8'({PCWrite, MemWrite, RegWrite, IRWrite, MulStart}), 8'h0);
    reset = 1'b0;
    #1;
    st("rr_after", FETCH);
    step();
    st("rr_dec", DECODE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
